// File: rtl/spi_reg_master_if.sv
// Command/response bundle for spi_reg_master: valid/ready command in, one-cycle response strobe out.
// The master modport is the requester; the slave modport is the SPI controller.
interface spi_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 controller: one 16-bit frame per accepted command, rsp_valid 1+34*CLK_DIV cycles after accept,
// ready only in IDLE (no queuing). `define SPI_LOOPBACK_EN makes the receiver sample copi instead of cipo.
module spi_reg_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_reg_master_if.slave   cmd,
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  input  logic              cipo
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          sclk_q, sclk_d;
  logic          ncs_q, ncs_d;
  logic          copi_q, copi_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          div_end;
  logic          rx_bit;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = copi_q;
  logic unused_cipo;
  assign unused_cipo = cipo;
`else
  assign rx_bit = cipo;
`endif

  // Every non-idle phase lasts a whole number of CLK_DIV segments, so the
  // divider simply free-runs and reloads itself at each segment boundary.
  assign div_end = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_end ? DIV_LAST : div_q - DW'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;
    rsp_vld_d = 1'b0;
    rsp_dat_d = rsp_dat_q;

    case (state_q)
      IDLE: begin
        div_d = DIV_LAST;
        if (cmd.cmd_valid) begin
          state_d = SETUP;
          tx_d    = {cmd.cmd_write, cmd.cmd_addr, cmd.cmd_write ? cmd.cmd_wdata : 8'h00};
          copi_d  = cmd.cmd_write;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = 4'd15;
          rx_d    = 8'h00;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], rx_bit};
        end
      end
      SHIFT: begin
        if (div_end) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != 4'd0) copi_d = tx_q[bit_q - 4'd1];
          end else if (bit_q == 4'd0) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q - 4'd1;
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], rx_bit};
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d   = GAP;
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          rsp_vld_d = 1'b1;
          rsp_dat_d = rx_q;
        end
      end
      GAP: begin
        if (div_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= DIV_LAST;
      bit_q     <= 4'd15;
      tx_q      <= 16'h0000;
      rx_q      <= 8'h00;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.rsp_valid = rsp_vld_q;
  assign cmd.rsp_rdata = rsp_dat_q;
  assign sclk          = sclk_q;
  assign ncs           = ncs_q;
  assign copi          = copi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: CLK_DIV=4 instance with a mode-0 responder model, plus a CLK_DIV=1
// instance whose cipo is wired back to its own copi.
module tb_spi_reg_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_master_if bus4 ();
  spi_reg_master_if bus1 ();

  logic sclk4, ncs4, copi4;
  logic cipo4 = 1'b0;
  logic sclk1, ncs1, copi1, cipo1;
  assign cipo1 = copi1;

  spi_reg_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd(bus4),
    .sclk(sclk4), .ncs(ncs4), .copi(copi4), .cipo(cipo4)
  );

  spi_reg_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd(bus1),
    .sclk(sclk1), .ncs(ncs1), .copi(copi1), .cipo(cipo1)
  );

  // Responder + monitor for the CLK_DIV=4 link, evaluated mid-cycle.
  logic [15:0] resp_word = 16'h0000;
  logic [15:0] resp_sr = 16'h0000;
  logic [15:0] cap = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  int rises = 0, last_rises = 0, low = 0, last_low = 0, gap = 0, last_gap = 0, rsp_cnt4 = 0;

  always @(negedge clk) begin
    if (ncs4) begin
      if (!prev_ncs) begin
        last_frame <= cap;
        last_rises <= rises;
        last_low   <= low;
        gap        <= 1;
      end else begin
        gap <= gap + 1;
      end
      resp_sr <= resp_word;
      cipo4   <= resp_word[15];
    end else if (prev_ncs) begin
      last_gap <= gap;
      low      <= 1;
      rises    <= 0;
      cap      <= 16'h0000;
    end else begin
      low <= low + 1;
      if (sclk4 && !prev_sclk) begin
        cap   <= {cap[14:0], copi4};
        rises <= rises + 1;
      end
      if (!sclk4 && prev_sclk) begin
        resp_sr <= {resp_sr[14:0], 1'b0};
        cipo4   <= resp_sr[14];
      end
    end
    if (bus4.rsp_valid) rsp_cnt4 <= rsp_cnt4 + 1;
    prev_ncs  <= ncs4;
    prev_sclk <= sclk4;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Called on a negedge; returns the accept cycle, then scrambles cmd_* to prove the frame was latched.
  task automatic send4(input logic w, input logic [6:0] ad, input logic [7:0] d, output int acc);
    acc = -1;
    bus4.cmd_valid = 1'b1;
    bus4.cmd_write = w;
    bus4.cmd_addr  = ad;
    bus4.cmd_wdata = d;
    for (int k = 0; k < 400; k++) begin
      if (bus4.cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus4.cmd_valid = 1'b0;
    bus4.cmd_write = ~w;
    bus4.cmd_addr  = ~ad;
    bus4.cmd_wdata = ~d;
  endtask

  task automatic wait_rsp4(output int r, output logic [7:0] rd);
    r  = -1;
    rd = 8'h00;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus4.rsp_valid) begin
        r  = cyc;
        rd = bus4.rsp_rdata;
        break;
      end
    end
  endtask

  task automatic wait_ready4(output int rc);
    rc = -1;
    for (int k = 0; k < 400; k++) begin
      if (bus4.cmd_ready) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] resp;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int a, a2, r, rc, bad, base;
    logic [7:0] rd;

    vecs[0] = '{w:1'b1, addr:7'h04, wdata:8'hA5, resp:16'h1234, frame:16'h84A5, rdata:8'h34};
    vecs[1] = '{w:1'b0, addr:7'h02, wdata:8'h77, resp:16'h003C, frame:16'h0200, rdata:8'h3C};
    vecs[2] = '{w:1'b1, addr:7'h7F, wdata:8'h00, resp:16'hFFFF, frame:16'hFF00, rdata:8'hFF};
    vecs[3] = '{w:1'b0, addr:7'h55, wdata:8'hFF, resp:16'hA5C3, frame:16'h5500, rdata:8'hC3};

    bus4.cmd_valid = 1'b0; bus4.cmd_write = 1'b0; bus4.cmd_addr = 7'h00; bus4.cmd_wdata = 8'h00;
    bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = 7'h00; bus1.cmd_wdata = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ncs4 !== 1'b1 || sclk4 !== 1'b0 || copi4 !== 1'b0 || bus4.cmd_ready !== 1'b1 ||
          bus4.busy !== 1'b0 || bus4.rsp_valid !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check("rst_ncs", ncs4, 1'b1);
    check("rst_sclk", sclk4, 1'b0);
    check("rst_ready", bus4.cmd_ready, 1'b1);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_rdata", bus4.rsp_rdata, 8'h00);
    check("rst_ncs_div1", ncs1, 1'b1);

    // Single frames: latency, framing and read data.
    for (int i = 0; i < 4; i++) begin
      resp_word = vecs[i].resp;
      base = rsp_cnt4;
      send4(vecs[i].w, vecs[i].addr, vecs[i].wdata, a);
      check($sformatf("v%0d_busy", i), bus4.busy, 1'b1);
      wait_rsp4(r, rd);
      check($sformatf("v%0d_rsp_lat", i), r - a, 137);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      wait_ready4(rc);
      check($sformatf("v%0d_ready_lat", i), rc - a, 141);
      check($sformatf("v%0d_frame", i), last_frame, vecs[i].frame);
      check($sformatf("v%0d_rises", i), last_rises, 16);
      check($sformatf("v%0d_ncs_low", i), last_low, 136);
      check($sformatf("v%0d_rsp_pulses", i), rsp_cnt4 - base, 1);
      @(negedge clk);
    end

    // Back-to-back with cmd_valid held; the second command is presented during the first frame.
    resp_word = 16'h0000;
    bus4.cmd_valid = 1'b1; bus4.cmd_write = 1'b1; bus4.cmd_addr = 7'h00; bus4.cmd_wdata = 8'hFF;
    wait_ready4(a);
    @(negedge clk);
    bus4.cmd_addr = 7'h01; bus4.cmd_wdata = 8'h0F;
    @(negedge clk);
    wait_ready4(a2);
    check("b2b_period", a2 - a, 141);
    @(negedge clk);
    bus4.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_frame1", last_frame, 16'h80FF);
    // GAP plus the IDLE accept cycle keep ncs high for CLK_DIV+1 cycles.
    check("b2b_gap", last_gap, 5);
    wait_rsp4(r, rd);
    check("b2b_rsp2_lat", r - a2, 137);
    wait_ready4(rc);
    check("b2b_frame2", last_frame, 16'h810F);

    // Reset during bit 7 of the shift phase.
    @(negedge clk);
    resp_word = 16'hFFFF;
    send4(1'b1, 7'h33, 8'h66, a);
    for (int k = 0; k < 200 && cyc < a + 70; k++) @(negedge clk);
    check("mid_sclk_high", {ncs4, sclk4}, 2'b01);
    base = rsp_cnt4;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ncs", ncs4, 1'b1);
    check("abort_sclk", sclk4, 1'b0);
    check("abort_busy", bus4.busy, 1'b0);
    check("abort_rsp", bus4.rsp_valid, 1'b0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_rsp", rsp_cnt4 - base, 0);
    check("abort_rdata", bus4.rsp_rdata, 8'h00);
    resp_word = vecs[0].resp;
    send4(vecs[0].w, vecs[0].addr, vecs[0].wdata, a);
    wait_rsp4(r, rd);
    check("post_abort_lat", r - a, 137);
    check("post_abort_rdata", rd, vecs[0].rdata);
    wait_ready4(rc);
    check("post_abort_frame", last_frame, vecs[0].frame);

    // CLK_DIV=1, data looped back from copi.
    @(negedge clk);
    bus1.cmd_valid = 1'b1; bus1.cmd_write = 1'b1; bus1.cmd_addr = 7'h7F; bus1.cmd_wdata = 8'h5A;
    check("d1_ready", bus1.cmd_ready, 1'b1);
    a = cyc;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (sclk1 !== ((k % 2) == 0) || ncs1 !== 1'b0) bad++;
    end
    check("d1_sclk_toggle", bad, 0);
    r = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        r = cyc;
        rd = bus1.rsp_rdata;
        break;
      end
    end
    check("d1_rsp_lat", r - a, 35);
    check("d1_wr_rdata", rd, 8'h5A);
    rc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus1.cmd_ready) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("d1_ready_lat", rc - a, 36);
    bus1.cmd_valid = 1'b1; bus1.cmd_write = 1'b0; bus1.cmd_addr = 7'h7F; bus1.cmd_wdata = 8'hFF;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    rd = 8'hEE;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        rd = bus1.rsp_rdata;
        break;
      end
    end
    check("d1_rd_rdata", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
